wb_arbiter: RTL

Round-robin arbiter that shares one Wishbone classic slave port (the register-map CSR block) between `N_MST` Wishbone masters, such as the testbench bus driver, a debug bridge and a DMA engine. A master holds the bus for as long as it keeps `cyc` asserted. The arbiter routes that master's request signals to the slave and routes the slave's `ack` back to it alone. A watchdog ends stalled cycles with an error pulse so a missing slave cannot hang the bus.

---
 rtl/wb_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Brief    : Round-robin arbiter sharing one Wishbone classic slave port
//            between N_MST masters. The bus owner keeps it while cyc is high;
//            a watchdog aborts stalled cycles with a one-cycle error pulse.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int STRB_W  = DATA_W / 8,
    parameter int N_MST   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    // master side
    input  logic [N_MST*ADDR_W-1:0]   m_adr_i,
    input  logic [N_MST*DATA_W-1:0]   m_dat_i,
    input  logic [N_MST*STRB_W-1:0]   m_sel_i,
    input  logic [N_MST-1:0]          m_we_i,
    input  logic [N_MST-1:0]          m_stb_i,
    input  logic [N_MST-1:0]          m_cyc_i,
    output logic [DATA_W-1:0]         m_dat_o,
    output logic [N_MST-1:0]          m_ack_o,
    output logic [N_MST-1:0]          m_err_o,
    // slave side
    output logic [ADDR_W-1:0]         wb_adr_o,
    output logic [DATA_W-1:0]         wb_dat_o,
    output logic [STRB_W-1:0]         wb_sel_o,
    output logic                      wb_we_o,
    output logic                      wb_stb_o,
    output logic                      wb_cyc_o,
    input  logic [DATA_W-1:0]         wb_dat_i,
    input  logic                      wb_ack_i,
    // debug
    output logic [N_MST-1:0]          gnt_o,
    output logic                      busy_o
);

    localparam int LAST_W = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    // Watchdog fires on the edge that closes the TIMEOUT-th stalled cycle.
    localparam logic [WD_W-1:0]   c_WD_LAST  = WD_W'(TIMEOUT - 1);
    // Previous owner after reset is the highest index so master 0 wins first.
    localparam logic [LAST_W-1:0] c_LAST_RST = LAST_W'(N_MST - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t              r_state;
    logic [N_MST-1:0]    r_gnt;
    logic [N_MST-1:0]    r_err;
    logic [LAST_W-1:0]   r_last;
    logic [WD_W-1:0]     r_wdog;

    logic                w_any;
    logic [LAST_W-1:0]   w_pick_idx;
    logic [N_MST-1:0]    w_pick_oh;
    int                  w_scan;

    logic                w_grant_act;
    logic                w_own_cyc;
    logic [ADDR_W-1:0]   w_adr;
    logic [DATA_W-1:0]   w_dat;
    logic [STRB_W-1:0]   w_sel;
    logic                w_we;
    logic                w_stb;
    logic                w_cyc;

    // Round-robin pick: first requester scanning last+1, last+2, ... mod N_MST.
    always_comb begin
        w_any      = 1'b0;
        w_pick_idx = '0;
        w_pick_oh  = '0;
        w_scan     = 0;
        for (int i = 1; i <= N_MST; i++) begin
            w_scan = (int'(r_last) + i) % N_MST;
            for (int k = 0; k < N_MST; k++) begin
                if (!w_any && (w_scan == k) && m_cyc_i[k]) begin
                    w_any        = 1'b1;
                    w_pick_idx   = LAST_W'(k);
                    w_pick_oh[k] = 1'b1;
                end
            end
        end
    end

    assign w_grant_act = (r_state == S_GRANT);
    assign w_own_cyc   = |(r_gnt & m_cyc_i);

    // Route only the owner's request to the slave; zero outside GRANT.
    always_comb begin
        w_adr = '0;
        w_dat = '0;
        w_sel = '0;
        w_we  = 1'b0;
        w_stb = 1'b0;
        w_cyc = 1'b0;
        for (int k = 0; k < N_MST; k++) begin
            if (w_grant_act && r_gnt[k]) begin
                w_adr = m_adr_i[k*ADDR_W +: ADDR_W];
                w_dat = m_dat_i[k*DATA_W +: DATA_W];
                w_sel = m_sel_i[k*STRB_W +: STRB_W];
                w_we  = m_we_i[k];
                w_stb = m_stb_i[k];
                w_cyc = m_cyc_i[k];
            end
        end
    end

    assign wb_adr_o = w_adr;
    assign wb_dat_o = w_dat;
    assign wb_sel_o = w_sel;
    assign wb_we_o  = w_we;
    assign wb_stb_o = w_stb;
    assign wb_cyc_o = w_cyc;

    // Ack and read data are pass-through; ack is steered to the owner only.
    assign m_ack_o = w_grant_act ? (r_gnt & {N_MST{wb_ack_i}}) : '0;
    assign m_dat_o = wb_dat_i;
    assign m_err_o = r_err;
    assign gnt_o   = r_gnt;
    assign busy_o  = |r_gnt;

    // Arbitration FSM with watchdog; grant and error are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_err   <= '0;
            r_last  <= c_LAST_RST;
            r_wdog  <= '0;
        end else begin
            r_err <= '0;
            case (r_state)
                S_IDLE: begin
                    r_wdog <= '0;
                    if (w_any) begin
                        r_gnt   <= w_pick_oh;
                        r_last  <= w_pick_idx;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (!w_own_cyc) begin
                        r_state <= S_IDLE;
                        r_gnt   <= '0;
                        r_wdog  <= '0;
                    end else if (w_stb && !wb_ack_i) begin
                        if (r_wdog == c_WD_LAST) begin
                            r_state <= S_ABORT;
                            r_err   <= r_gnt;
                            r_wdog  <= '0;
                        end else begin
                            r_wdog <= r_wdog + WD_W'(1);
                        end
                    end else begin
                        // ack (even on the timeout edge) or idle strobe clears it
                        r_wdog <= '0;
                    end
                end
                S_ABORT: begin
                    // owner keeps the grant until it drops cyc
                    if (!w_own_cyc) begin
                        r_state <= S_IDLE;
                        r_gnt   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_wdog  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
